// File: rtl/dmem_responder.sv
// Memory-side responder for the hart data port: byte-maskable word SRAM with a
// configurable read latency and a ready/valid handshake.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic        o_dmem_ready,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_valid,
  output logic        o_dmem_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] LatInit = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StRdWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   hold_q, hold_d;
  logic          err_q, err_d;
  logic [31:0]   mem [DEPTH];

  logic [31:0]   offset;
  logic [31:0]   lane_mask;
  logic [AW-1:0] idx;
  logic          accept;
  logic          req_err;
  logic          is_read;
  logic          do_write;

  assign offset    = i_dmem_addr - BASE_ADDR;
  assign idx       = offset[AW+1:2];
  assign lane_mask = {{8{i_dmem_mask[3]}}, {8{i_dmem_mask[2]}},
                      {8{i_dmem_mask[1]}}, {8{i_dmem_mask[0]}}};
  assign req_err   = (i_dmem_addr[1:0] != 2'b00) || (i_dmem_addr < BASE_ADDR) ||
                     ((offset >> 2) >= DEPTH) || (i_dmem_ren && i_dmem_wen) ||
                     (i_dmem_mask == 4'b0000);
  assign accept    = (state_q == StIdle) && (i_dmem_ren || i_dmem_wen);
  assign is_read   = i_dmem_ren && !i_dmem_wen;
  assign do_write  = accept && i_rst_n && i_dmem_wen && !i_dmem_ren && !req_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          err_d  = req_err;
          // Unselected lanes read back as zero; errors and writes return zero data.
          hold_d = (is_read && !req_err) ? (mem[idx] & lane_mask) : 32'h0;
          if (is_read) begin
            cnt_d   = LatInit;
            state_d = (READ_LATENCY == 1) ? StResp : StRdWait;
          end else begin
            state_d = StResp;
          end
        end
      end
      StRdWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      hold_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately left uninitialised across reset.
  always_ff @(posedge i_clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (i_dmem_mask[b]) mem[idx][8*b +: 8] <= i_dmem_wdata[8*b +: 8];
      end
    end
  end

  assign o_dmem_ready = (state_q == StIdle);
  assign o_dmem_valid = (state_q == StResp);
  assign o_dmem_rdata = o_dmem_valid ? hold_q : 32'h0;
  assign o_dmem_err   = o_dmem_valid && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed checks of dmem_responder against a word-array reference
// model, across three instances with read latencies 2, 1 and 15.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr  [3];
  logic        ren   [3];
  logic        wen   [3];
  logic [31:0] wdata [3];
  logic [3:0]  mask  [3];
  logic        ready [3];
  logic [31:0] rdata [3];
  logic        valid [3];
  logic        err   [3];

  logic [31:0] model [3][1024];
  int          n_checks;
  int          n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .BASE_ADDR   ((g == 1) ? 32'h0000_1000 : 32'h0000_0000),
      .DEPTH       ((g == 2) ? 16 : 1024),
      .READ_LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 15))
    ) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_dmem_addr (addr[g]),
      .i_dmem_ren  (ren[g]),
      .i_dmem_wen  (wen[g]),
      .i_dmem_wdata(wdata[g]),
      .i_dmem_mask (mask[g]),
      .o_dmem_ready(ready[g]),
      .o_dmem_rdata(rdata[g]),
      .o_dmem_valid(valid[g]),
      .o_dmem_err  (err[g])
    );
  end

  function automatic int unsigned lat_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  function automatic logic [31:0] base_of(int k);
    return (k == 1) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  function automatic int unsigned depth_of(int k);
    return (k == 2) ? 16 : 1024;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction on instance k, with expectations from the model.
  task automatic xact(input int k, input logic [31:0] a, input logic r, input logic w,
                      input logic [31:0] wd, input logic [3:0] m, output logic [31:0] got);
    logic        e;
    int          el;
    int          lat;
    int          busy_rdy;
    int          nw;
    logic [31:0] er;
    logic [31:0] lanes;
    int unsigned widx;
    lanes = 32'h0;
    for (int b = 0; b < 4; b++) if (m[b]) lanes[8*b +: 8] = 8'hFF;
    e = (a % 4 != 0) || (a < base_of(k)) || (r && w) || (m == 4'b0000);
    if (!e && ((a - base_of(k)) / 4 >= depth_of(k))) e = 1'b1;
    widx = (a - base_of(k)) / 4;
    if (e) el = (r && !w) ? int'(lat_of(k)) : 1;
    else   el = w ? 1 : int'(lat_of(k));
    er = 32'h0;
    if (!e && r) er = model[k][widx] & lanes;
    if (!e && w) model[k][widx] = (model[k][widx] & ~lanes) | (wd & lanes);

    @(negedge clk);
    addr[k] = a; ren[k] = r; wen[k] = w; wdata[k] = wd; mask[k] = m;
    nw = 0;
    while (!ready[k] && nw < 40) begin
      @(negedge clk);
      nw++;
    end
    check($sformatf("ready_idle[%0d]", k), 32'(ready[k]), 32'd1);
    @(posedge clk);
    #1;
    ren[k] = 1'b0; wen[k] = 1'b0;
    lat = 1;
    busy_rdy = 0;
    while (!valid[k] && lat < 40) begin
      if (ready[k]) busy_rdy++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (ready[k]) busy_rdy++;
    check($sformatf("latency[%0d]", k), 32'(lat), 32'(el));
    check($sformatf("ready_busy[%0d]", k), 32'(busy_rdy), 32'd0);
    check($sformatf("err[%0d]", k), 32'(err[k]), 32'(e));
    check($sformatf("rdata[%0d]", k), rdata[k], er);
    got = rdata[k];
    @(posedge clk);
    #1;
    check($sformatf("valid_pulse[%0d]", k), 32'(valid[k]), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    logic [31:0] exp_q[$];
    logic [31:0] ex;
    int          sel, op, last, nacc, nv, a_sel;
    logic        rdy;
    logic [3:0]  m;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      addr[k] = 32'h0; ren[k] = 1'b0; wen[k] = 1'b0; wdata[k] = 32'h0; mask[k] = 4'h0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_ready", 32'(ready[k]), 32'd1);
      check("reset_valid", 32'(valid[k]), 32'd0);
      check("reset_err", 32'(err[k]), 32'd0);
      check("reset_rdata", rdata[k], 32'h0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed write/read, byte lanes and error cases on the latency-2 instance.
    xact(0, 32'h40, 1'b0, 1'b1, 32'hDEADBEEF, 4'b1111, got);
    xact(0, 32'h40, 1'b1, 1'b0, 32'h0, 4'b1111, got);
    check("wr_rd", got, 32'hDEADBEEF);
    xact(0, 32'h40, 1'b0, 1'b1, 32'h55000000, 4'b1000, got);
    xact(0, 32'h40, 1'b1, 1'b0, 32'h0, 4'b1111, got);
    check("byte_full", got, 32'h55ADBEEF);
    xact(0, 32'h40, 1'b1, 1'b0, 32'h0, 4'b1100, got);
    check("byte_half", got, 32'h55AD0000);
    xact(0, 32'h42, 1'b1, 1'b0, 32'h0, 4'b1111, got);
    xact(0, 32'h1000, 1'b0, 1'b1, 32'h11111111, 4'b1111, got);
    xact(0, 32'h40, 1'b1, 1'b1, 32'h22222222, 4'b1111, got);
    xact(0, 32'h40, 1'b1, 1'b0, 32'h0, 4'b0000, got);
    xact(0, 32'h40, 1'b0, 1'b1, 32'h33333333, 4'b0000, got);
    xact(0, 32'h40, 1'b1, 1'b0, 32'h0, 4'b1111, got);
    check("err_no_change", got, 32'h55ADBEEF);
    xact(1, 32'h0FFC, 1'b1, 1'b0, 32'h0, 4'b1111, got);

    // Stall: read request held high, alternating between word 0 and word 1.
    xact(0, 32'h0, 1'b0, 1'b1, 32'hA5A5_0000, 4'b1111, got);
    xact(0, 32'h4, 1'b0, 1'b1, 32'h0000_5A5A, 4'b1111, got);
    @(negedge clk);
    a_sel = 0; addr[0] = 32'h0; mask[0] = 4'hF; ren[0] = 1'b1;
    last = -1; nacc = 0; nv = 0;
    for (int c = 0; c < 30; c++) begin
      rdy = ready[0];
      @(posedge clk);
      #1;
      if (valid[0]) begin
        nv++;
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
        check("stall_rdata", rdata[0], ex);
      end
      if (rdy) begin
        if (last >= 0) check("stall_gap", 32'(c - last), 32'd3);
        last = c;
        nacc++;
        exp_q.push_back(model[0][a_sel]);
        a_sel ^= 1;
        addr[0] = 32'(a_sel * 4);
      end
      @(negedge clk);
    end
    ren[0] = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (valid[0]) begin
        nv++;
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
        check("stall_rdata", rdata[0], ex);
      end
    end
    check("stall_count", 32'(nv), 32'(nacc));

    // Reset in the middle of a long read.
    xact(2, 32'h20, 1'b0, 1'b1, 32'h12345678, 4'b1111, got);
    @(negedge clk);
    addr[2] = 32'h20; ren[2] = 1'b1; mask[2] = 4'hF;
    @(posedge clk);
    #1;
    ren[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(ready[2]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(ready[2]), 32'd1);
    check("rst_valid", 32'(valid[2]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      nv += int'(valid[2]);
    end
    check("rst_no_valid", 32'(nv), 32'd0);
    xact(2, 32'h20, 1'b1, 1'b0, 32'h0, 4'b1111, got);
    check("rst_keep", got, 32'h12345678);

    // Randomised traffic on all three latencies.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++)
        xact(k, base_of(k) + 32'(4 * i), 1'b0, 1'b1, $urandom, 4'b1111, got);
      for (int i = 0; i < 40; i++) begin
        sel = $urandom_range(0, 9);
        op  = $urandom_range(0, 5);
        m   = 4'($urandom_range(1, 15));
        a   = base_of(k) + 32'(4 * $urandom_range(0, 15));
        if (sel == 0) a = a + 32'($urandom_range(1, 3));
        if (sel == 1) a = base_of(k) + 32'(4 * depth_of(k)) + 32'(4 * $urandom_range(0, 3));
        if (sel == 2 && base_of(k) != 0) a = base_of(k) - 32'd4;
        if (sel == 3) m = 4'b0000;
        xact(k, a, (op <= 2) || (op == 5), (op >= 3), $urandom, m, got);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (memory side) of the hart data-memory port: word-organised, byte-maskable SRAM model with configurable read latency and an explicit ready/valid handshake.
- Replaces the zero-latency combinational dmem so the hart can be exercised against realistic memory timing.
- Sits between the hart dmem outputs and the testbench/SoC; the hart stalls on o_dmem_ready low and waits for o_dmem_valid.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of word 0; word-aligned.
- DEPTH, 1024: number of 32-bit words; power of 2, 16..65536.
- READ_LATENCY, 2: cycles from read acceptance edge to o_dmem_valid; legal 1..15.

Ports:
- i_clk  input  1  global clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_dmem_addr  input  32  byte address of request.
- i_dmem_ren  input  1  read request.
- i_dmem_wen  input  1  write request.
- i_dmem_wdata  input  32  write data, lanes already shifted.
- i_dmem_mask  input  4  byte-lane enables; bit n = bits [8n+7:8n].
- o_dmem_ready  output  1  request accepted at next rising edge if ren|wen.
- o_dmem_rdata  output  32  read data; valid only with o_dmem_valid.
- o_dmem_valid  output  1  one-cycle completion pulse, reads and writes.
- o_dmem_err  output  1  error qualifier, meaningful only with o_dmem_valid.

Behaviour:
- Reset (async assert, sync release): state IDLE, latency counter 0, o_dmem_ready=1, o_dmem_valid=0, o_dmem_err=0, o_dmem_rdata=0. Memory array not cleared. Reset mid-read or mid-response aborts it; no valid pulse is issued.
- Accept: rising edge with state==IDLE and (ren|wen). o_dmem_ready = (state==IDLE). Requests while ready=0 are ignored; requester holds them.
- Word index = (addr - BASE_ADDR) >> 2.
- Error if any holds: addr[1:0]!=0; addr<BASE_ADDR or index>=DEPTH; ren&wen both set; mask==0. Error request: no array access; after normal latency (READ_LATENCY if ren only, else 1), valid=1, err=1, rdata=0.
- Write: on accept edge, lanes with mask bit set are written; other lanes unchanged. Next cycle state RESP: valid=1, err=0, rdata=0.
- Read: on accept edge, array word is snapshotted, masked (unselected lanes forced 0) into a hold register, and counter loaded with READ_LATENCY-1.
  - READ_LATENCY==1: go to RESP directly.
  - Otherwise go to RD_WAIT, decrement each cycle, enter RESP when counter==1 at an edge.
  - Valid asserts exactly READ_LATENCY cycles after the accept edge.
- States and transitions:
  - IDLE -> RD_WAIT or RESP on accept.
  - RD_WAIT -> RESP on counter expiry.
  - RESP -> IDLE unconditionally after 1 cycle.
  - ready=0 in RD_WAIT and RESP.
- Outputs in RESP only: valid=1, rdata=hold register, err=error flag. All three are 0 outside RESP.
- Throughput limits: max one write per 2 cycles; one read per READ_LATENCY+1 cycles.
- Read-after-write to the same word returns the new data; the write commits before the next accept is possible.
- No combinational path from inputs to any output; all outputs are registered or decoded from state.

Test Plan:
- Write then read: addr 0x40, wdata 0xDEADBEEF, mask 1111, then read 0x40, mask 1111, READ_LATENCY=2. Required: write valid 1 cycle after accept with err=0; read valid exactly 2 cycles after accept with rdata=0xDEADBEEF; ready low during wait.
- Byte write: sb at 0x43, mask 1000, wdata 0x55000000, over 0xDEADBEEF, then full read. Required: 0x55ADBEEF. Half read, mask 1100: 0x55AD0000.
- Errors: addr 0x42 read, addr BASE+4*DEPTH write, ren&wen both set, mask 0000. Required: each gives valid with err=1, rdata=0; memory unchanged on re-read.
- Stall: hold ren high continuously at 0x0 and 0x4 alternating. Required: accepts only when ready=1, spaced READ_LATENCY+1 cycles; no duplicate valid pulses.
- Reset mid-read: assert i_rst_n=0 during RD_WAIT. Required: valid never pulses; ready=1 immediately on assert; prior write data still readable after release.
- Latency sweep: READ_LATENCY 1, 2, 15. Required: valid-to-accept distance equals the parameter in every case.
